// File: rtl/sram_ctrl_pkg.sv
// Shared types and widths for the CPU data-memory to asynchronous SRAM bridge.
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WSETUP,
    WPULSE,
    WHOLD,
    ACK
  } state_t;

  localparam int WAIT_W  = 4;
  localparam int SRAM_AW = 17;
  localparam int SRAM_DW = 16;

  // States in which the SRAM is selected (address on the pins is meaningful).
  function automatic logic sram_selected(input state_t s);
    return (s == RD) || (s == WSETUP) || (s == WPULSE) || (s == WHOLD);
  endfunction

  // States in which the controller drives the shared data pads.
  function automatic logic drives_pad(input state_t s);
    return (s == WSETUP) || (s == WPULSE) || (s == WHOLD);
  endfunction

endpackage

// File: rtl/sram_ctrl.sv
// Bridges single-outstanding dm_req/dm_ack transactions onto an asynchronous 16-bit SRAM
// with non-overlapping oe/we strobes and an idle gap on the pads between write and read.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int   WAIT_STATES = 1,
  parameter logic ADDR_HI     = 1'b0
) (
  input  logic                clk_cpu,
  input  logic                rst,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [15:0]         dm_adr,
  input  logic [15:0]         dm_dat_o,
  output logic [15:0]         dm_dat_i,
  output logic                dm_ack,
  output logic                busy,
  output logic                err_abort,
  output logic                sram_cs_n,
  output logic                sram_oe_n,
  output logic                sram_we_n,
  output logic [SRAM_AW-1:0]  sram_adr,
  output logic [SRAM_DW-1:0]  sram_dat_o,
  output logic                sram_dat_oe,
  input  logic [SRAM_DW-1:0]  sram_dat_i
);

  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_STATES);

  state_t              state_reg, state_next;
  logic [WAIT_W-1:0]   cnt_reg, cnt_next;
  logic [SRAM_AW-1:0]  adr_reg;
  logic [SRAM_DW-1:0]  wdat_reg;
  logic [SRAM_DW-1:0]  rdat_reg;
  logic                err_reg;

  always_ff @(posedge clk_cpu) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      adr_reg   <= '0;
      wdat_reg  <= '0;
      rdat_reg  <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      // Request fields are captured once; later changes on dm_* are ignored.
      if (state_reg == IDLE && dm_req) begin
        adr_reg  <= {ADDR_HI, dm_adr};
        wdat_reg <= dm_dat_o;
      end
      if (state_reg == RD && cnt_reg == '0) begin
        rdat_reg <= sram_dat_i;
      end
      if (sram_selected(state_reg) && !dm_req) begin
        err_reg <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (dm_req) begin
          if (dm_we) begin
            state_next = WSETUP;
          end else begin
            state_next = RD;
            cnt_next   = WAIT_LOAD;
          end
        end
      end
      RD: begin
        if (cnt_reg == '0) state_next = ACK;
        else               cnt_next   = cnt_reg - WAIT_W'(1);
      end
      WSETUP: begin
        state_next = WPULSE;
        cnt_next   = WAIT_LOAD;
      end
      WPULSE: begin
        if (cnt_reg == '0) state_next = WHOLD;
        else               cnt_next   = cnt_reg - WAIT_W'(1);
      end
      WHOLD:   state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes decode straight from the state register so a reset drops them on the next edge.
  always_comb begin
    sram_cs_n   = !sram_selected(state_reg);
    sram_oe_n   = (state_reg != RD);
    sram_we_n   = (state_reg != WPULSE);
    sram_dat_oe = drives_pad(state_reg);
    dm_ack      = (state_reg == ACK);
    busy        = (state_reg != IDLE);
  end

  assign sram_adr   = adr_reg;
  assign sram_dat_o = wdat_reg;
  assign dm_dat_i   = rdat_reg;
  assign err_abort  = err_reg;

endmodule
